board_enable_controller: RTL and testbench

Generates the 100 µs system tick and the global board `enable` that drives the CPU power sequencer. Holds `enable` low for 10 ms after CPLD power-on and debounces the host/switch power request. Latches supply faults and forces a minimum off-time so the sequencer's 10 ms shutdown always completes before a restart. Sits directly upstream of the CPU power sequencer in the CPLD.

---
 rtl/board_enable_controller.sv | 137 +++++++++++++
 tb/tb_board_enable_controller.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/board_enable_controller.sv
// board_enable_controller
//   Generates the 100 us system tick and the global board enable that feeds
//   the CPU power sequencer. Holds enable low for POR_TICKS after power-on,
//   debounces the power request, latches supply faults and enforces a
//   minimum off-time before any restart.
//
// Ports
//   sysclk        in   single clock for the block
//   reset_INV     in   asynchronous active-low reset
//   pwr_req       in   asynchronous power request, high = on
//   fault         in   asynchronous supply fault, high = fault
//   enable        out  registered board enable (high only in ON)
//   tick_100us    out  registered one-cycle tick pulse
//   state         out  current FSM state for status readback
//   fault_latched out  registered sticky fault flag
module board_enable_controller #(
  parameter int unsigned TICK_DIV       = 500,
  parameter int unsigned POR_TICKS      = 100,
  parameter int unsigned DEBOUNCE_TICKS = 20,
  parameter int unsigned MIN_OFF_TICKS  = 100
) (
  input  logic       sysclk,
  input  logic       reset_INV,
  input  logic       pwr_req,
  input  logic       fault,
  output logic       enable,
  output logic       tick_100us,
  output logic [2:0] state,
  output logic       fault_latched
);

  typedef enum logic [2:0] {
    POR_WAIT = 3'b000,
    OFF      = 3'b001,
    ON       = 3'b010,
    FAULT    = 3'b011,
    HOLDOFF  = 3'b100
  } state_t;

  localparam logic [9:0] TICK_LAST = 10'(TICK_DIV - 1);
  localparam logic [7:0] DB_LAST   = 8'(DEBOUNCE_TICKS - 1);
  localparam logic [7:0] POR_T     = 8'(POR_TICKS);
  localparam logic [7:0] MOFF_T    = 8'(MIN_OFF_TICKS);

  logic       req_m, req_s;
  logic       fault_m, fault_s;
  logic [9:0] presc;
  logic       req_db;
  logic [7:0] db_cnt;
  logic [7:0] timer;
  state_t     state_q, state_d;
  logic       fault_clr;

  // Two-flop synchronisers for the asynchronous inputs
  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      req_m   <= 1'b0;
      req_s   <= 1'b0;
      fault_m <= 1'b0;
      fault_s <= 1'b0;
    end else begin
      req_m   <= pwr_req;
      req_s   <= req_m;
      fault_m <= fault;
      fault_s <= fault_m;
    end
  end

  // Prescaler; the registered tick is also the internal timebase
  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      presc      <= '0;
      tick_100us <= 1'b0;
    end else begin
      tick_100us <= (presc == TICK_LAST);
      if (presc == TICK_LAST) presc <= '0;
      else                    presc <= presc + 10'd1;
    end
  end

  // Debounce: a mismatch must persist across DEBOUNCE_TICKS ticks
  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      req_db <= 1'b0;
      db_cnt <= '0;
    end else if (req_s == req_db) begin
      db_cnt <= '0;
    end else if (tick_100us) begin
      if (db_cnt == DB_LAST) begin
        req_db <= req_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q != FAULT && fault_latched) begin
      state_d = FAULT;
    end else begin
      case (state_q)
        POR_WAIT: if (timer == POR_T)          state_d = OFF;
        OFF:      if (req_db)                  state_d = ON;
        ON:       if (!req_db)                 state_d = HOLDOFF;
        FAULT:    if (!fault_s && !req_db)     state_d = HOLDOFF;
        HOLDOFF:  if (timer == MOFF_T)         state_d = OFF;
        default:                               state_d = OFF;
      endcase
    end
  end

  assign fault_clr = (state_q == FAULT) && (state_d == HOLDOFF);

  // FSM, state timer, fault latch; enable is registered from the next state
  // so it moves on the same edge that state enters or leaves ON.
  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      state_q       <= POR_WAIT;
      timer         <= '0;
      enable        <= 1'b0;
      fault_latched <= 1'b0;
    end else begin
      state_q <= state_d;
      enable  <= (state_d == ON);
      if (state_d != state_q)                timer <= '0;
      else if (tick_100us && timer != 8'hFF) timer <= timer + 8'd1;
      // set wins over clear
      if (fault_s)        fault_latched <= 1'b1;
      else if (fault_clr) fault_latched <= 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_board_enable_controller.sv
module tb_board_enable_controller;

  localparam int TD  = 4;
  localparam int POR = 3;
  localparam int DB  = 2;
  localparam int MOF = 3;

  localparam int S_POR = 0, S_OFF = 1, S_ON = 2, S_FAULT = 3, S_HOLD = 4;

  logic       sysclk = 1'b0;
  logic       reset_INV = 1'b0;
  logic       pwr_req = 1'b0;
  logic       fault = 1'b0;
  logic       enable;
  logic       tick_100us;
  logic [2:0] state;
  logic       fault_latched;

  int n_cmp = 0;
  int n_bad = 0;

  board_enable_controller #(
    .TICK_DIV(TD), .POR_TICKS(POR), .DEBOUNCE_TICKS(DB), .MIN_OFF_TICKS(MOF)
  ) dut (
    .sysclk(sysclk), .reset_INV(reset_INV), .pwr_req(pwr_req), .fault(fault),
    .enable(enable), .tick_100us(tick_100us), .state(state),
    .fault_latched(fault_latched)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tick derived from elapsed cycles, synchronisers as input history,
  // state timer as ticks elapsed since the state was entered.
  int m_cyc, m_ticks, m_entry, m_run, m_state;
  bit m_tick, m_req_db, m_fl, m_en;
  bit req_h[2];
  bit flt_h[2];

  always @(posedge sysclk or negedge reset_INV) begin : model
    bit rs, fs, tk;
    int tmr, nxt;
    if (!reset_INV) begin
      m_cyc = 0; m_ticks = 0; m_entry = 0; m_run = 0; m_state = S_POR;
      m_tick = 0; m_req_db = 0; m_fl = 0; m_en = 0;
      req_h[0] = 0; req_h[1] = 0; flt_h[0] = 0; flt_h[1] = 0;
    end else begin
      rs  = req_h[1];
      fs  = flt_h[1];
      tk  = m_tick;
      tmr = m_ticks - m_entry;
      if (tmr > 255) tmr = 255;
      nxt = m_state;
      if (m_state != S_FAULT && m_fl) nxt = S_FAULT;
      else if (m_state == S_POR   && tmr == POR)  nxt = S_OFF;
      else if (m_state == S_OFF   && m_req_db)    nxt = S_ON;
      else if (m_state == S_ON    && !m_req_db)   nxt = S_HOLD;
      else if (m_state == S_FAULT && !fs && !m_req_db) nxt = S_HOLD;
      else if (m_state == S_HOLD  && tmr == MOF)  nxt = S_OFF;
      if (fs) m_fl = 1;
      else if (m_state == S_FAULT && nxt == S_HOLD) m_fl = 0;
      if (rs == m_req_db) m_run = 0;
      else if (tk) begin
        m_run++;
        if (m_run == DB) begin m_req_db = rs; m_run = 0; end
      end
      if (tk) m_ticks++;
      if (nxt != m_state) m_entry = m_ticks;
      m_state = nxt;
      m_en = (nxt == S_ON);
      req_h[1] = req_h[0]; req_h[0] = pwr_req;
      flt_h[1] = flt_h[0]; flt_h[0] = fault;
      m_cyc++;
      m_tick = (m_cyc % TD == 0);
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge sysclk) begin
    check("state", int'(state), m_state);
    check("enable", int'(enable), int'(m_en));
    check("tick", int'(tick_100us), int'(m_tick));
    check("fault_latched", int'(fault_latched), int'(m_fl));
  end

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic wait_state(input string name, input int s, input int budget);
    int k;
    k = 0;
    while (int'(state) != s && k < budget) begin
      step();
      k++;
    end
    n_cmp++;
    if (int'(state) != s) begin
      n_bad++;
      $display("FAIL %s: state %0d, wanted %0d within %0d cycles", name, state, s, budget);
    end
  endtask

  initial begin : stim
    int n, hold, rst_cnt;
    // ---- power-on with request held ----
    reset_INV = 0; pwr_req = 1; fault = 0;
    repeat (3) @(posedge sysclk);
    #1;
    check("reset_state", int'(state), S_POR);
    check("reset_enable", int'(enable), 0);
    check("reset_tick", int'(tick_100us), 0);
    check("reset_fl", int'(fault_latched), 0);
    reset_INV = 1;
    for (int i = 1; i <= 16; i++) begin
      step();
      check("po_tick", int'(tick_100us), (i % 4 == 0) ? 1 : 0);
      check("po_state", int'(state), (i <= 13) ? S_POR : (i == 14 ? S_OFF : S_ON));
      check("po_enable", int'(enable), (i >= 15) ? 1 : 0);
    end

    // ---- debounce: short glitch ignored ----
    repeat (10) step();
    pwr_req = 0;
    repeat (3) step();
    pwr_req = 1;
    for (int i = 0; i < 12; i++) begin
      step();
      check("glitch_enable", int'(enable), 1);
    end
    // ---- sustained low: enable falls within 11 cycles ----
    pwr_req = 0;
    n = 0;
    while (enable && n < 11) begin step(); n++; end
    check("db_fall_enable", int'(enable), 0);
    check("db_fall_state", int'(state), S_HOLD);
    // ---- re-request during HOLDOFF ----
    pwr_req = 1;
    n = 0;
    while (int'(state) == S_HOLD && n < 20) begin
      step(); n++;
    end
    n_cmp++;
    if (n < 12 || n > 16) begin
      n_bad++;
      $display("FAIL holdoff_len: got %0d cycles expected 12..16", n);
    end
    check("holdoff_exit", int'(state), S_OFF);
    check("holdoff_exit_en", int'(enable), 0);
    step();
    check("rereq_on", int'(state), S_ON);
    check("rereq_en", int'(enable), 1);

    // ---- fault in ON ----
    repeat (5) step();
    fault = 1;
    step();
    fault = 0;
    step();
    step();
    check("flt_en_hold", int'(enable), 1);
    check("flt_latched", int'(fault_latched), 1);
    step();
    check("flt_en_low", int'(enable), 0);
    check("flt_state", int'(state), S_FAULT);
    repeat (100) step();
    check("flt_stuck", int'(state), S_FAULT);
    check("flt_stuck_fl", int'(fault_latched), 1);

    // ---- fault recovery ----
    pwr_req = 0;
    wait_state("rec_holdoff", S_HOLD, 30);
    check("rec_fl_clear", int'(fault_latched), 0);
    wait_state("rec_off", S_OFF, 30);
    pwr_req = 1;
    wait_state("rec_on", S_ON, 30);
    check("rec_enable", int'(enable), 1);

    // ---- async reset mid-cycle in ON ----
    repeat (3) step();
    #2 reset_INV = 0;
    #1;
    check("arst_enable", int'(enable), 0);
    check("arst_state", int'(state), S_POR);
    check("arst_fl", int'(fault_latched), 0);
    repeat (3) step();
    reset_INV = 1;

    // ---- randomized operation ----
    hold = 0;
    rst_cnt = 0;
    for (int i = 0; i < 4000; i++) begin
      step();
      fault = ($urandom_range(0, 199) == 0);
      if (hold == 0) begin
        pwr_req = ~pwr_req;
        hold = $urandom_range(1, 60);
      end else begin
        hold--;
      end
      if (rst_cnt > 0) begin
        rst_cnt--;
        if (rst_cnt == 0) reset_INV = 1;
      end else if ($urandom_range(0, 1499) == 0) begin
        reset_INV = 0;
        rst_cnt = 2;
      end
    end
    reset_INV = 1;
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
